wb_data_select: RTL
===================

# wb_data_select

Parametrised, pipelined writeback-data selector for the multicycle datapath. It replaces the flat combinational memory-to-register mux. It picks one of `N_SRC` source words and, when the memory source is picked, extracts and sign- or zero-extends a byte or halfword. It presents the result to the register file through a two-stage valid/ready pipeline. Out-of-range selects and illegal load shapes produce a defined default value and sticky error flags.

## Interface
- `WIDTH`, 32: data width. Must be ≥ 32.
- `N_SRC`, 9: number of sources. Must be ≥ 2.
- `SEL_W`, `$clog2(N_SRC)`: selector width.
- `MEM_SRC`, 1: source index that receives load alignment/extension.
- `DEFAULT_VAL`, 227: value output for an out-of-range select.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high
- `in_valid`  in  1  request present
- `in_ready`  out  1  request accepted this cycle when `in_valid & in_ready`
- `sel`  in  SEL_W  source index
- `src_data`  in  N_SRC*WIDTH  flattened sources; source k is at `[k*WIDTH +: WIDTH]`
- `ld_size`  in  2  00 word, 01 half, 10 byte, 11 reserved
- `ld_signed`  in  1  1 = sign-extend, 0 = zero-extend
- `byte_off`  in  2  byte address offset within the word
- `out_valid`  out  1  result present
- `out_ready`  in  1  consumer accepts
- `data_out`  out  WIDTH  result
- `err`  out  3  sticky errors: [0] sel ≥ N_SRC, [1] ld_size = 11, [2] misaligned half (`byte_off[0]` = 1)
- `err_clr`  in  1  clears `err`

## Operation
- **Stage 1 (capture).** On accept, register the selected word and `ld_size`, `ld_signed`, `byte_off` and an `is_mem` flag (`sel == MEM_SRC`).
  - If `sel ≥ N_SRC`: the captured word is `DEFAULT_VAL`, `is_mem` = 0, and `err[0]` is set.
- **Stage 2 (align).** When stage 2 loads:
  - `is_mem` = 0: pass the word unchanged, regardless of `ld_size`.
  - `is_mem` = 1, word: pass unchanged.
  - `is_mem` = 1, half: take `word[byte_off[1]*16 +: 16]` and extend to `WIDTH`. If `byte_off[0]` = 1, set `err[2]` and still use `byte_off[1]`.
  - `is_mem` = 1, byte: take `word[byte_off*8 +: 8]` and extend to `WIDTH`.
  - `is_mem` = 1, reserved size: treat as word and set `err[1]`.
- **Error flags.**
  - An error is recorded in the cycle its stage registers the request: `err[0]` on stage-1 accept, `err[1]`/`err[2]` on stage-2 load.
  - If `err_clr` and a new error occur in the same cycle, the new error bit ends up set; other bits clear.
  - Error checks for `ld_size`/`byte_off` apply only to `is_mem` requests.
- **Flow control.**
  - `adv2 = !s2_valid | out_ready`
  - `adv1 = !s1_valid | adv2`
  - `in_ready = adv1`, which is combinational from `out_ready`.
  - No request is dropped or duplicated. Order is preserved.

## Timing
- On reset: `s1_valid` = 0, `s2_valid` = 0, `out_valid` = 0, `data_out` = 0, `err` = 0. `in_ready` is 1 in the cycle after reset deasserts.
- Reset asserted mid-operation discards all in-flight requests and errors on that edge.
- Latency: a request accepted at edge n appears with `out_valid` = 1 after edge n+1 (2-cycle pipeline).
- Throughput: 1 request per cycle while `out_ready` = 1.
- Holding `out_ready` = 0:
  - `data_out` and `out_valid` hold.
  - After at most 2 accepted requests, `in_ready` drops.
  - When `out_ready` rises, `in_ready` reasserts in the same cycle.
- `data_out` changes only when stage 2 loads. It is stable while `out_valid & !out_ready`.

## Structure
- Shared package `wb_pkg`:
  - load-size constants `LD_WORD`, `LD_HALF`, `LD_BYTE`, `LD_RSVD`
  - error-bit indices `ERR_SEL`, `ERR_SIZE`, `ERR_ALIGN`
- One sub-module, `load_extend`: combinational byte/half extraction and sign/zero extension, parametrised by `WIDTH`, instantiated in stage 2.
- The pipeline registers and flow control are in the top level.

## Test plan
- Reset, then `sel`=4 with source 4 = 0x1234_5678, `out_ready`=1 -> `data_out` = 0x1234_5678 two cycles after accept; `err` = 0.
- `sel`=1 (mem), word 0x80FF_7F01, byte, `byte_off`=2, signed -> 0xFFFF_FFFF. Same request unsigned -> 0x0000_00FF.
- `sel`=1, word 0x8001_7FFE, half, `byte_off`=3, signed -> 0xFFFF_8001 and `err[2]` = 1. Then `err_clr` -> `err` = 0.
- `sel`=12 with N_SRC=9 -> `data_out` = 227 and `err[0]` = 1. Same request in the same cycle as `err_clr` -> `err[0]` remains 1.
- Back-to-back requests A, B, C with `out_ready`=0 for 4 cycles -> `in_ready` low after A and B are held. Releasing gives A, B, C in order with no loss.
- Assert `reset` while 2 requests are in flight -> next cycle `out_valid` = 0, `data_out` = 0, `err` = 0, and no stale output afterwards.

Source files
------------

// File: rtl/wb_data_select_pkg.sv
// Shared constants and payload types for the writeback-data selector.
// Load-size encodings, error-bit positions and the load-control bundle.
package wb_pkg;

    localparam logic [1:0] LD_WORD = 2'b00;
    localparam logic [1:0] LD_HALF = 2'b01;
    localparam logic [1:0] LD_BYTE = 2'b10;
    localparam logic [1:0] LD_RSVD = 2'b11;

    localparam int unsigned ERR_SEL   = 0;
    localparam int unsigned ERR_SIZE  = 1;
    localparam int unsigned ERR_ALIGN = 2;
    localparam int unsigned ERR_W     = 3;

    // Load shape carried alongside the captured word from stage 1 to stage 2
    typedef struct packed {
        logic [1:0] size;
        logic       sgn;
        logic [1:0] off;
        logic       is_mem;
    } ld_ctrl_t;

endpackage

// File: rtl/wb_data_select_load_extend.sv
// Combinational load alignment: picks a byte/half of a memory word and
// sign- or zero-extends it; flags reserved sizes and misaligned halves.
module load_extend
    import wb_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_word,
    input  ld_ctrl_t         i_ctrl,
    output logic [WIDTH-1:0] o_data_c,
    output logic             o_err_size_c,
    output logic             o_err_align_c
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    // Misaligned halves still use off[1] to choose the upper or lower half
    assign w_half = i_ctrl.off[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        w_byte = i_word[7:0];
        case (i_ctrl.off)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
    end

    always_comb begin
        o_data_c      = i_word;
        o_err_size_c  = 1'b0;
        o_err_align_c = 1'b0;
        if (i_ctrl.is_mem) begin
            case (i_ctrl.size)
                LD_HALF: begin
                    o_data_c      = {{(WIDTH-16){i_ctrl.sgn & w_half[15]}}, w_half};
                    o_err_align_c = i_ctrl.off[0];
                end
                LD_BYTE: begin
                    o_data_c = {{(WIDTH-8){i_ctrl.sgn & w_byte[7]}}, w_byte};
                end
                LD_RSVD: begin
                    o_err_size_c = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/wb_data_select.sv
// Two-stage valid/ready writeback-data selector: stage 1 captures the selected
// source, stage 2 applies load alignment and drives the register-file result.
module wb_data_select
    import wb_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned N_SRC       = 9,
    parameter int unsigned SEL_W       = $clog2(N_SRC),
    parameter int unsigned MEM_SRC     = 1,
    parameter int unsigned DEFAULT_VAL = 227
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SEL_W-1:0]       sel,
    input  logic [N_SRC*WIDTH-1:0] src_data,
    input  logic [1:0]             ld_size,
    input  logic                   ld_signed,
    input  logic [1:0]             byte_off,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       data_out,
    output logic [ERR_W-1:0]       err,
    input  logic                   err_clr
);

    logic             w_adv1;
    logic             w_adv2;
    logic             w_accept;
    logic             w_s2_load;
    logic             w_sel_oob;
    logic             w_is_mem;
    logic [WIDTH-1:0] w_sel_word;
    ld_ctrl_t         w_s1_ctrl;
    logic [WIDTH-1:0] w_aligned;
    logic             w_err_size;
    logic             w_err_align;
    logic [ERR_W-1:0] w_err_set;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_word;
    ld_ctrl_t         r_s1_ctrl;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_data_out;
    logic [ERR_W-1:0] r_err;

    assign w_adv2    = !r_s2_valid | out_ready;
    assign w_adv1    = !r_s1_valid | w_adv2;
    assign w_accept  = in_valid & w_adv1;
    assign w_s2_load = r_s1_valid & w_adv2;
    assign in_ready  = w_adv1;

    assign w_sel_oob = (32'(sel) >= N_SRC);
    assign w_is_mem  = !w_sel_oob && (32'(sel) == MEM_SRC);

    // Source mux; an out-of-range select falls through to the default value
    always_comb begin
        w_sel_word = WIDTH'(DEFAULT_VAL);
        for (int unsigned k = 0; k < N_SRC; k++) begin
            if (32'(sel) == k) begin
                w_sel_word = src_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_s1_ctrl = '{size: ld_size, sgn: ld_signed, off: byte_off, is_mem: w_is_mem};

    load_extend #(
        .WIDTH(WIDTH)
    ) u_load_extend (
        .i_word        (r_s1_word),
        .i_ctrl        (r_s1_ctrl),
        .o_data_c      (w_aligned),
        .o_err_size_c  (w_err_size),
        .o_err_align_c (w_err_align)
    );

    // New errors are raised by whichever stage registers the offending request
    always_comb begin
        w_err_set            = '0;
        w_err_set[ERR_SEL]   = w_accept & w_sel_oob;
        w_err_set[ERR_SIZE]  = w_s2_load & w_err_size;
        w_err_set[ERR_ALIGN] = w_s2_load & w_err_align;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_word  <= '0;
            r_s1_ctrl  <= '0;
            r_s2_valid <= 1'b0;
            r_data_out <= '0;
            r_err      <= '0;
        end else begin
            if (w_adv1) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_word <= w_sel_word;
                    r_s1_ctrl <= w_s1_ctrl;
                end
            end
            if (w_adv2) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_data_out <= w_aligned;
                end
            end
            // A clear never hides an error raised in the same cycle
            r_err <= (err_clr ? '0 : r_err) | w_err_set;
        end
    end

    assign out_valid = r_s2_valid;
    assign data_out  = r_data_out;
    assign err       = r_err;

endmodule
